// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache, one word per line
module icache_direct #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clr,
    input  logic                  if_to_ic_enable,
    input  logic [ADDR_WIDTH-1:0] if_to_ic_pc,
    output logic                  ic_to_if_done,
    output logic [31:0]           ic_to_if_inst,
    output logic                  ic_to_mc_enable,
    output logic [ADDR_WIDTH-1:0] ic_to_mc_pc,
    input  logic                  mc_to_ic_done,
    input  logic [31:0]           mc_to_ic_result
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               state;
    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [31:0]          data_mem [LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  accept;
    logic                  fill;
    logic                  unused_pc_bits;

    // Byte offset within the word never matters to a word-per-line cache.
    assign unused_pc_bits = ^if_to_ic_pc[1:0];

    assign req_index = if_to_ic_pc[INDEX_BITS+1:2];
    assign req_tag   = if_to_ic_pc[ADDR_WIDTH-1:INDEX_BITS+2];

    // The outstanding miss address lives in ic_to_mc_pc; it stays stable for the whole refill.
    assign fill_index = ic_to_mc_pc[INDEX_BITS+1:2];
    assign fill_tag   = ic_to_mc_pc[ADDR_WIDTH-1:INDEX_BITS+2];

    assign hit    = valid[req_index] && (tag_mem[req_index] == req_tag);
    // The done guard keeps the still-held request from being accepted twice.
    assign accept = if_to_ic_enable && !clr && !ic_to_if_done;
    // A returning word is always written, even when the request was flushed (DROP).
    assign fill   = rdy && (state != IDLE) && mc_to_ic_done;

    // Tag and data arrays: written only on refill, no reset needed since valid gates them.
    always_ff @(posedge clk) begin
        if (!rst && fill) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mc_to_ic_result;
        end
    end

    // Control FSM with registered outputs and the valid bits; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            valid           <= '0;
            ic_to_if_done   <= 1'b0;
            ic_to_if_inst   <= '0;
            ic_to_mc_enable <= 1'b0;
            ic_to_mc_pc     <= '0;
        end else if (rdy) begin
            ic_to_if_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            ic_to_if_done <= 1'b1;
                            ic_to_if_inst <= data_mem[req_index];
                        end else begin
                            ic_to_mc_enable <= 1'b1;
                            ic_to_mc_pc     <= {if_to_ic_pc[ADDR_WIDTH-1:2], 2'b00};
                            state           <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mc_to_ic_done) begin
                        valid[fill_index] <= 1'b1;
                        ic_to_mc_enable   <= 1'b0;
                        state             <= IDLE;
                        if (!clr) begin
                            ic_to_if_done <= 1'b1;
                            ic_to_if_inst <= mc_to_ic_result;
                        end
                    end else if (clr) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (mc_to_ic_done) begin
                        valid[fill_index] <= 1'b1;
                        ic_to_mc_enable   <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: begin
                    state           <= IDLE;
                    ic_to_mc_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard bench for icache_direct
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        if_to_ic_enable;
    logic [31:0] if_to_ic_pc;
    logic        ic_to_if_done;
    logic [31:0] ic_to_if_inst;
    logic        ic_to_mc_enable;
    logic [31:0] ic_to_mc_pc;
    logic        mc_to_ic_done;
    logic [31:0] mc_to_ic_result;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    icache_direct #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .clr             (clr),
        .if_to_ic_enable (if_to_ic_enable),
        .if_to_ic_pc     (if_to_ic_pc),
        .ic_to_if_done   (ic_to_if_done),
        .ic_to_if_inst   (ic_to_if_inst),
        .ic_to_mc_enable (ic_to_mc_enable),
        .ic_to_mc_pc     (ic_to_mc_pc),
        .mc_to_ic_done   (mc_to_ic_done),
        .mc_to_ic_result (mc_to_ic_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every done pulse must match the oldest expected instruction.
    always @(negedge clk) begin
        if (!rst && ic_to_if_done) begin
            if (exp_q.size() == 0)
                check("spurious_done", 32'(ic_to_if_done), 32'd0);
            else
                check("inst", ic_to_if_inst, exp_q.pop_front());
        end
    end

    task automatic req_hit(input logic [31:0] pc, input logic [31:0] word);
        if_to_ic_enable = 1'b1;
        if_to_ic_pc     = pc;
        exp_q.push_back(word);
        step();
        check("hit_done", 32'(ic_to_if_done), 32'd1);
        check("hit_mc_en", 32'(ic_to_mc_enable), 32'd0);
        if_to_ic_enable = 1'b0;
        step();
        check("hit_pulse", 32'(ic_to_if_done), 32'd0);
    endtask

    task automatic req_miss(input logic [31:0] pc, input logic [31:0] word, input int lat,
                            input bit clr_on_done);
        logic [31:0] aligned;
        aligned         = {pc[31:2], 2'b00};
        if_to_ic_enable = 1'b1;
        if_to_ic_pc     = pc;
        step();
        check("miss_mc_en", 32'(ic_to_mc_enable), 32'd1);
        check("miss_mc_pc", ic_to_mc_pc, aligned);
        check("miss_no_done", 32'(ic_to_if_done), 32'd0);
        for (int i = 1; i < lat; i++) begin
            step();
            check("miss_hold_en", 32'(ic_to_mc_enable), 32'd1);
            check("miss_hold_pc", ic_to_mc_pc, aligned);
        end
        mc_to_ic_done   = 1'b1;
        mc_to_ic_result = word;
        clr             = clr_on_done;
        if (clr_on_done) if_to_ic_enable = 1'b0;
        else exp_q.push_back(word);
        step();
        mc_to_ic_done = 1'b0;
        clr           = 1'b0;
        check("fill_mc_en", 32'(ic_to_mc_enable), 32'd0);
        check("fill_done", 32'(ic_to_if_done), 32'(!clr_on_done));
        if_to_ic_enable = 1'b0;
        step();
        check("fill_pulse", 32'(ic_to_if_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        if_to_ic_enable = 1'b0; if_to_ic_pc = '0;
        mc_to_ic_done = 1'b0; mc_to_ic_result = '0;
        step(); step();
        check("rst_done", 32'(ic_to_if_done), 32'd0);
        check("rst_inst", ic_to_if_inst, 32'd0);
        check("rst_mc_en", 32'(ic_to_mc_enable), 32'd0);
        check("rst_mc_pc", ic_to_mc_pc, 32'd0);
        rst = 1'b0;
        step();

        // Cold miss then hit after fill.
        req_miss(32'h0000_0104, 32'h0000_0013, 5, 1'b0);
        req_hit(32'h0000_0104, 32'h0000_0013);

        // Conflict on index 1, then the original line misses again; low pc bits ignored.
        req_miss(32'h0000_0204, 32'hDEAD_BEEF, 3, 1'b0);
        req_hit(32'h0000_0206, 32'hDEAD_BEEF);
        req_miss(32'h0000_0104, 32'h0000_0013, 2, 1'b0);
        req_hit(32'h0000_0107, 32'h0000_0013);

        // Flush mid-miss: refill completes silently.
        if_to_ic_enable = 1'b1;
        if_to_ic_pc     = 32'h0000_0300;
        step();
        check("flush_mc_en0", 32'(ic_to_mc_enable), 32'd1);
        step();
        clr = 1'b1;
        if_to_ic_enable = 1'b0;
        step();
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("flush_hold_en", 32'(ic_to_mc_enable), 32'd1);
            check("flush_no_done", 32'(ic_to_if_done), 32'd0);
            step();
        end
        check("flush_hold_pc", ic_to_mc_pc, 32'h0000_0300);
        mc_to_ic_done   = 1'b1;
        mc_to_ic_result = 32'h1111_1111;
        step();
        mc_to_ic_done = 1'b0;
        check("flush_fill_en", 32'(ic_to_mc_enable), 32'd0);
        check("flush_fill_done", 32'(ic_to_if_done), 32'd0);
        step();
        req_hit(32'h0000_0300, 32'h1111_1111);

        // clr coincident with what would be a hit acceptance.
        if_to_ic_enable = 1'b1;
        if_to_ic_pc     = 32'h0000_0300;
        clr             = 1'b1;
        step();
        clr = 1'b0;
        if_to_ic_enable = 1'b0;
        check("clr_hit_done", 32'(ic_to_if_done), 32'd0);
        check("clr_hit_mc_en", 32'(ic_to_mc_enable), 32'd0);
        step();

        // clr coincident with mc_to_ic_done: no response, line still filled.
        req_miss(32'h0000_0400, 32'h2222_2222, 2, 1'b1);
        req_hit(32'h0000_0400, 32'h2222_2222);

        // rdy low for 4 cycles during MISS.
        if_to_ic_enable = 1'b1;
        if_to_ic_pc     = 32'h0000_050B;
        step();
        step();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rdy_mc_en", 32'(ic_to_mc_enable), 32'd1);
            check("rdy_mc_pc", ic_to_mc_pc, 32'h0000_0508);
            check("rdy_done", 32'(ic_to_if_done), 32'd0);
        end
        rdy = 1'b1;
        step();
        check("rdy_back_en", 32'(ic_to_mc_enable), 32'd1);
        mc_to_ic_done   = 1'b1;
        mc_to_ic_result = 32'hCAFE_F00D;
        exp_q.push_back(32'hCAFE_F00D);
        step();
        mc_to_ic_done   = 1'b0;
        if_to_ic_enable = 1'b0;
        check("rdy_fill_done", 32'(ic_to_if_done), 32'd1);
        check("rdy_fill_en", 32'(ic_to_mc_enable), 32'd0);
        step();
        req_hit(32'h0000_0508, 32'hCAFE_F00D);

        step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
